// File: rtl/vpifo_req_sched.sv
// vpifo_req_sched
//   Shares the LEVEL push/pop lanes of a virtualized PIFO among NUM_REQ
//   requesters. Tree t is served by lane t % LEVEL. Each lane grants one
//   request per cycle round-robin. Per-tree occupancy counters block overflow.
//   Pops to an empty tree are answered with an error and are not issued.
//   Every pop response arrives POP_LAT+2 cycles after its grant.
//
// Ports
//   i_clk, i_arst_n   clock (rising edge), asynchronous active-low reset
//   i_req_*           per-requester request: valid, op (0 push / 1 pop),
//                     tree id, push data
//   o_req_ready       combinational grant; accepted when valid & ready
//   o_rsp_*           per-requester pop response: 1-cycle strobe, error
//                     flag, popped data (0 on error)
//   o_push, o_pop     registered PIFO lane commands
//   o_push_data       push data per lane, holds when the lane is idle
//   o_tree_id         tree id per lane, holds when the lane is idle
//   i_pop_data        PIFO pop result, valid POP_LAT cycles after o_pop
//   i_task_fifo_full  per-lane backpressure, blocks pushes only
module vpifo_req_sched #(
  parameter int PTW      = 16,
  parameter int LEVEL    = 4,
  parameter int TREE_NUM = 4,
  parameter int NUM_REQ  = 4,
  parameter int TREE_CAP = 4 * ((4 ** LEVEL - 1) / 3),
  parameter int POP_LAT  = 2,
  localparam int TW = (TREE_NUM > 1) ? $clog2(TREE_NUM) : 1,
  localparam int RW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          i_clk,
  input  logic                          i_arst_n,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ-1:0]            i_req_op,
  input  logic [NUM_REQ-1:0][TW-1:0]    i_req_tree_id,
  input  logic [NUM_REQ-1:0][PTW-1:0]   i_req_data,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic [NUM_REQ-1:0]            o_rsp_valid,
  output logic [NUM_REQ-1:0]            o_rsp_err,
  output logic [NUM_REQ-1:0][PTW-1:0]   o_rsp_data,
  output logic [LEVEL-1:0]              o_push,
  output logic [LEVEL-1:0]              o_pop,
  output logic [LEVEL-1:0][PTW-1:0]     o_push_data,
  output logic [LEVEL-1:0][TW-1:0]      o_tree_id,
  input  logic [LEVEL-1:0][PTW-1:0]     i_pop_data,
  input  logic [LEVEL-1:0]              i_task_fifo_full
);

  localparam int CW = $clog2(TREE_CAP + 1);
  localparam logic [CW-1:0] CAP = CW'(TREE_CAP);

  function automatic int unsigned lane_of(input logic [TW-1:0] t);
    return 32'(t) % LEVEL;
  endfunction

  logic [TREE_NUM-1:0][CW-1:0] cnt, cnt_nxt;
  logic [LEVEL-1:0][RW-1:0]    rr_ptr, rr_nxt;
  logic [NUM_REQ-1:0]          elig;

  // per-lane winner of this cycle
  logic [LEVEL-1:0]            g_vld, g_pop, g_hit;
  logic [LEVEL-1:0][RW-1:0]    g_req;
  logic [LEVEL-1:0][TW-1:0]    g_tree;
  logic [LEVEL-1:0][PTW-1:0]   g_data;

  // tag pipeline: stage 0 is visible with the lane command, stage POP_LAT
  // lines up with i_pop_data
  logic [LEVEL-1:0][POP_LAT:0]         tag_v, tag_e;
  logic [LEVEL-1:0][POP_LAT:0][RW-1:0] tag_id;

  logic [NUM_REQ-1:0]          rsp_v_nxt, rsp_e_nxt;
  logic [NUM_REQ-1:0][PTW-1:0] rsp_d_nxt;

  always_comb begin
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      elig[r] = i_req_valid[r] &&
                (i_req_op[r] ||
                 ((cnt[i_req_tree_id[r]] < CAP) &&
                  !i_task_fifo_full[lane_of(i_req_tree_id[r])]));
    end
  end

  always_comb begin
    g_vld       = '0;
    g_pop       = '0;
    g_hit       = '0;
    g_req       = '0;
    g_tree      = '0;
    g_data      = '0;
    o_req_ready = '0;
    rr_nxt      = rr_ptr;
    cnt_nxt     = cnt;
    for (int unsigned l = 0; l < LEVEL; l++) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        logic [RW-1:0] idx;
        idx = RW'((32'(rr_ptr[l]) + k) % NUM_REQ);
        if (!g_vld[l] && elig[idx] && (lane_of(i_req_tree_id[idx]) == l)) begin
          g_vld[l]  = 1'b1;
          g_req[l]  = idx;
          g_pop[l]  = i_req_op[idx];
          g_tree[l] = i_req_tree_id[idx];
          g_data[l] = i_req_data[idx];
        end
      end
      if (g_vld[l]) begin
        o_req_ready[g_req[l]] = 1'b1;
        rr_nxt[l] = RW'((32'(g_req[l]) + 1) % NUM_REQ);
        // a tree belongs to exactly one lane, so each counter gets at most
        // one update here
        if (g_pop[l]) begin
          if (cnt[g_tree[l]] != '0) begin
            g_hit[l] = 1'b1;
            cnt_nxt[g_tree[l]] = cnt[g_tree[l]] - CW'(1);
          end
        end else begin
          cnt_nxt[g_tree[l]] = cnt[g_tree[l]] + CW'(1);
        end
      end
    end
  end

  // responses: a requester holds at most one grant per cycle and latency is
  // fixed, so two lanes never target the same requester in one cycle
  always_comb begin
    rsp_v_nxt = '0;
    rsp_e_nxt = '0;
    rsp_d_nxt = o_rsp_data;
    for (int unsigned l = 0; l < LEVEL; l++) begin
      if (tag_v[l][POP_LAT]) begin
        rsp_v_nxt[tag_id[l][POP_LAT]] = 1'b1;
        rsp_e_nxt[tag_id[l][POP_LAT]] = tag_e[l][POP_LAT];
        rsp_d_nxt[tag_id[l][POP_LAT]] = tag_e[l][POP_LAT] ? '0 : i_pop_data[l];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      cnt         <= '0;
      rr_ptr      <= '0;
      o_push      <= '0;
      o_pop       <= '0;
      o_push_data <= '0;
      o_tree_id   <= '0;
      tag_v       <= '0;
      tag_e       <= '0;
      tag_id      <= '0;
      o_rsp_valid <= '0;
      o_rsp_err   <= '0;
      o_rsp_data  <= '0;
    end else begin
      cnt    <= cnt_nxt;
      rr_ptr <= rr_nxt;
      for (int unsigned l = 0; l < LEVEL; l++) begin
        o_push[l] <= g_vld[l] && !g_pop[l];
        o_pop[l]  <= g_hit[l];
        if (g_vld[l] && !g_pop[l]) begin
          o_push_data[l] <= g_data[l];
        end
        if ((g_vld[l] && !g_pop[l]) || g_hit[l]) begin
          o_tree_id[l] <= g_tree[l];
        end
        // empty-tree pops still occupy a tag slot so error latency matches
        tag_v[l][0]  <= g_vld[l] && g_pop[l];
        tag_e[l][0]  <= !g_hit[l];
        tag_id[l][0] <= g_req[l];
        for (int unsigned k = 1; k <= POP_LAT; k++) begin
          tag_v[l][k]  <= tag_v[l][k-1];
          tag_e[l][k]  <= tag_e[l][k-1];
          tag_id[l][k] <= tag_id[l][k-1];
        end
      end
      o_rsp_valid <= rsp_v_nxt;
      o_rsp_err   <= rsp_e_nxt;
      o_rsp_data  <= rsp_d_nxt;
    end
  end

endmodule
